rr_arb8: RTL
============

# rr_arb8

Eight-requester round-robin arbiter that owns the select lines of the shared 8:1 `mux8` datapath in the core. It picks one valid requester per transfer, drives `sel` and routes the winner's payload through `mux8`. It handshakes with the requesters and the single consumer using valid/ready. It holds the grant stable while the consumer stalls and advances priority fairly after each accepted transfer.

## Interface
- `WIDTH`, default 32, payload width per requester; passed to `mux8`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_aL`  in  1  asynchronous active-low reset.
- `req_valid`  in  8  per-requester valid.
- `req_data`  in  WIDTH×8  per-requester payload.
- `req_last`  in  8  per-requester last-beat flag. Used only with the lock feature; ignored otherwise.
- `req_ready`  out  8  one-hot transfer acknowledge to the granted requester.
- `out_valid`  out  1  payload valid to the consumer.
- `out_data`  out  WIDTH  selected payload (`mux8` output).
- `out_ready`  in  1  consumer accept.
- `sel`  out  3  mux select, the binary index of the current grant.
- `grant`  out  8  one-hot current grant; all zero when `out_valid`=0.

## Operation
- **Transfer definition:** a transfer occurs when `out_valid` and `out_ready` are both 1 in the same cycle.
- **Requester rule:** a requester holds `req_valid` and `req_data` until it sees its `req_ready`. The arbiter's behaviour is undefined if a requester drops them early.
- **Priority pointer `ptr` (3 bits):**
  - The pick is the first valid requester at index `ptr`, `ptr+1`, … `ptr+7`, mod 8.
  - On each transfer with no lock, `ptr` ← granted index + 1 mod 8. Index 7 wraps to 0.
- **State machine:** IDLE, HOLD, LOCKED.
- **IDLE:**
  - The grant is the combinational pick from `req_valid` and `ptr`.
  - `out_valid` = OR of `req_valid`.
  - If `out_valid`=1 and `out_ready`=0, register the grant index into `hold_idx` and go to HOLD.
  - A transfer stays in IDLE and updates `ptr`.
- **HOLD:**
  - The grant is forced to `hold_idx`. New requesters that arrive in this state cannot steal the grant.
  - Remains in HOLD until a transfer occurs, then returns to IDLE and sets `ptr` ← `hold_idx`+1.
- **LOCKED** (only with the lock feature): see Configuration.
- **Outputs:**
  - `req_ready` = `grant` AND `out_ready`.
  - `sel` = binary encoding of `grant`. It is 0 when nothing is granted.
  - `out_data` = `req_data[sel]` through `mux8`.
- **All requesters valid:** every requester is served exactly once in 8 consecutive transfers.

## Timing
- Grant is zero-latency: `req_valid` leads to `out_valid`, `sel` and `out_data` in the same cycle.
- `ptr`, state and `hold_idx` update one cycle after a transfer or stall is observed, at the rising edge.
- **Reset (`rst_aL`=0, asynchronous):**
  - `ptr`=0, state=IDLE, `hold_idx`=0, `lock_idx`=0.
  - While reset is held: `out_valid`=0, `grant`=0, `req_ready`=0, `sel`=0.
- **Reset mid-HOLD or mid-LOCKED:** the held or locked grant is abandoned. After release, arbitration restarts from index 0.
- **Transfer in the same cycle a new requester arrives:** the new requester is considered only from the next cycle's pick.
- **No valid requesters:** `ptr` is unchanged and the state stays IDLE.

## Configuration
- Macro `RR_ARB8_LOCK_EN`.
- **Defined:** multi-beat packets are supported.
  - A transfer with `req_last[g]`=0 enters LOCKED with `lock_idx`=g and `ptr` unchanged.
  - In LOCKED the grant is forced to `lock_idx`. `out_valid` = `req_valid[lock_idx]`.
  - A transfer with `req_last`=1 returns to IDLE and sets `ptr` ← `lock_idx`+1.
  - A stall while locked stays in LOCKED; it does not enter HOLD.
- **Undefined:** the LOCKED state and `lock_idx` are absent. `req_last` is unused, and every transfer is a single beat.

## Structure
- The shared core package holds:
  - the state enum `arb_state_t` (IDLE, HOLD, LOCKED);
  - `ARB_N` = 8 and `ARB_IDX_W` = 3.
- Sub-module `rr_pick8`: combinational rotate/priority pick from `req_valid` and `ptr`, producing a one-hot grant and its index.
- The payload path instantiates the existing `mux8`, with `sel` driven by this block.

## Test plan
- **Reset:** hold `rst_aL`=0 with `req_valid`=8'hFF → `out_valid`=0, `req_ready`=0, `sel`=0. Release → `sel`=0 and `grant`=8'h01 on the first cycle.
- **Round-robin:** `req_valid`=8'hFF, `out_ready`=1 for 9 cycles → `sel` goes 0,1,…,7,0.
- **Skip and wrap:** `req_valid`=8'h81 with `ptr`=1 → grant index 7, then `ptr`=0 → grant index 0.
- **Hold:**
  - `req_valid`=8'h10, `out_ready`=0 → `sel`=4.
  - Then assert `req_valid[2]` while `ptr`=0 → `sel` stays 4 until `out_ready`=1.
  - After that, `ptr`=5.
- **Lock (`RR_ARB8_LOCK_EN`):**
  - Requester 3 sends 3 beats (`last` on beat 3) while `req_valid[1]`=1 → `sel`=3 for all 3 transfers.
  - Next `sel`=1.
- **Reset mid-LOCKED:** assert `rst_aL` during beat 2 → state IDLE and `ptr`=0 after release.

Source files
------------

// File: rtl/rr_arb8_pkg.sv
// Shared arbiter types and sizing for the eight-way round-robin arbiter.
// Pure declarations: no timing and no backpressure of its own.
// Imported by rr_pick8 and rr_arb8.
package rr_arb8_pkg;

    localparam int ARB_N     = 8;
    localparam int ARB_IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        LOCKED = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mux8.sv
// Shared 8:1 payload mux of the core datapath.
// Combinational, zero latency.
// No flow control; the select owner handles backpressure.
module mux8 #(
    parameter int WIDTH = 32
) (
    input  logic [7:0][WIDTH-1:0] in_data,
    input  logic [2:0]            sel,
    output logic [WIDTH-1:0]      out_data
);

    assign out_data = in_data[sel];

endmodule

// File: rtl/rr_pick8.sv
// Rotating priority pick: first valid requester at ptr, ptr+1, ... ptr+7 (mod 8).
// Combinational, zero latency.
// No flow control; any is low when no requester is valid.
module rr_pick8
    import rr_arb8_pkg::*;
(
    input  logic [ARB_N-1:0]     req_valid,
    input  logic [ARB_IDX_W-1:0] ptr,
    output logic [ARB_N-1:0]     pick,
    output logic [ARB_IDX_W-1:0] pick_idx,
    output logic                 any
);

    logic [ARB_IDX_W-1:0] cand;

    always_comb begin
        any      = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = 0; i < ARB_N; i++) begin
            cand = ptr + ARB_IDX_W'(i);
            if (!any && req_valid[cand]) begin
                any      = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign pick = any ? ({{(ARB_N-1){1'b0}}, 1'b1} << pick_idx) : '0;

endmodule

// File: rtl/rr_arb8.sv
// Eight-requester round-robin arbiter driving the mux8 select; RR_ARB8_LOCK_EN adds multi-beat lock.
// Zero-latency grant; ptr/state/hold_idx update at the edge after a transfer or stall.
// Grant held stable while out_ready is low; priority advances only on accepted transfers.
module rr_arb8
    import rr_arb8_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst_aL,
    input  logic [ARB_N-1:0]            req_valid,
    input  logic [ARB_N-1:0][WIDTH-1:0] req_data,
    input  logic [ARB_N-1:0]            req_last,
    output logic [ARB_N-1:0]            req_ready,
    output logic                        out_valid,
    output logic [WIDTH-1:0]            out_data,
    input  logic                        out_ready,
    output logic [ARB_IDX_W-1:0]        sel,
    output logic [ARB_N-1:0]            grant
);

    arb_state_t           state, state_nxt;
    logic [ARB_IDX_W-1:0] ptr, ptr_nxt;
    logic [ARB_IDX_W-1:0] hold_idx, hold_idx_nxt;
    logic [ARB_N-1:0]     pick;
    logic [ARB_IDX_W-1:0] pick_idx;
    logic                 pick_any;
    logic [ARB_IDX_W-1:0] grant_idx;
    logic                 cand_valid;
    logic                 xfer;
    logic                 last_beat;

`ifdef RR_ARB8_LOCK_EN
    logic [ARB_IDX_W-1:0] lock_idx, lock_idx_nxt;
    assign last_beat = req_last[grant_idx];
`else
    logic unused_last;
    assign unused_last = ^req_last;
    assign last_beat   = 1'b1;
`endif

    rr_pick8 u_pick (
        .req_valid (req_valid),
        .ptr       (ptr),
        .pick      (pick),
        .pick_idx  (pick_idx),
        .any       (pick_any)
    );

    always_comb begin
        grant_idx  = pick_idx;
        cand_valid = pick_any;
        case (state)
            HOLD: begin
                grant_idx  = hold_idx;
                cand_valid = req_valid[hold_idx];
            end
`ifdef RR_ARB8_LOCK_EN
            LOCKED: begin
                grant_idx  = lock_idx;
                cand_valid = req_valid[lock_idx];
            end
`endif
            default: ;
        endcase
    end

    // Outputs are forced quiet while reset is asserted, even with requesters valid.
    assign out_valid = rst_aL & cand_valid;
    assign grant     = out_valid ? ({{(ARB_N-1){1'b0}}, 1'b1} << grant_idx) : '0;
    assign sel       = out_valid ? grant_idx : '0;
    assign req_ready = grant & {ARB_N{out_ready}};
    assign xfer      = out_valid & out_ready;

    mux8 #(.WIDTH(WIDTH)) u_mux (
        .in_data  (req_data),
        .sel      (sel),
        .out_data (out_data)
    );

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        hold_idx_nxt = hold_idx;
`ifdef RR_ARB8_LOCK_EN
        lock_idx_nxt = lock_idx;
`endif
        if (xfer) begin
            if (last_beat) begin
                state_nxt = IDLE;
                ptr_nxt   = grant_idx + 3'd1;
            end else begin
                // Mid-packet beat: ptr stays put until the last beat is accepted.
                state_nxt = LOCKED;
`ifdef RR_ARB8_LOCK_EN
                lock_idx_nxt = grant_idx;
`endif
            end
        end else if (out_valid && state == IDLE) begin
            state_nxt    = HOLD;
            hold_idx_nxt = grant_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_idx <= '0;
`ifdef RR_ARB8_LOCK_EN
            lock_idx <= '0;
`endif
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            hold_idx <= hold_idx_nxt;
`ifdef RR_ARB8_LOCK_EN
            lock_idx <= lock_idx_nxt;
`endif
        end
    end

endmodule
